// File: rtl/sequence_pkg.sv
// Shared definitions for the serial frame transmitter and its detector peer.
package sequence_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SYNC = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam logic [3:0] SYNC_DEFAULT = 4'b1011;

  localparam int DATA_W_DEFAULT = 8;
  localparam int SYNC_W_DEFAULT = 4;
  localparam int GAP_W_DEFAULT  = 2;

  // Bits needed to hold the largest of the three phase lengths.
  function automatic int cnt_width(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// Parallel-load, MSB-first left shift register.
module serial_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data,
  output logic              msb
);

  logic [DATA_W-1:0] q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= data;
    end else if (shift) begin
      q <= q << 1;
    end
  end

  assign msb = q[DATA_W-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial frame transmitter: preamble, data word MSB-first, guard zeros.
module sequence_generator
  import sequence_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int SYNC_W = SYNC_W_DEFAULT,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(SYNC_DEFAULT),
  parameter int GAP_W  = GAP_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              abort,
  output logic              load_ready,
  output logic              sequence_out,
  output logic              frame_active,
  output logic              frame_done
);

  localparam int CNT_W = cnt_width(DATA_W, SYNC_W, GAP_W);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  =
    (GAP_W > 0) ? CNT_W'(GAP_W - 1) : '0;

  logic [1:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              done_d;
  logic              accept;
  logic              shift;
  logic              data_msb;
  logic [SYNC_W-1:0] sync_bits;

  serial_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clock (clock),
    .reset (reset),
    .load  (accept),
    .shift (shift),
    .data  (load_data),
    .msb   (data_msb)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      frame_done <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    done_d  = 1'b0;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_valid && !abort) begin
          accept  = 1'b1;
          state_d = SYNC;
          cnt_d   = SYNC_LAST;
        end
      end
      SYNC: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == '0) begin
          state_d = DATA;
          cnt_d   = DATA_LAST;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == '0) begin
          if (GAP_W > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LAST;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign sync_bits = SYNC_PATTERN >> cnt;
  assign shift     = (state == DATA);

  always_comb begin
    load_ready   = 1'b0;
    frame_active = 1'b0;
    sequence_out = 1'b0;
    unique case (state)
      IDLE: load_ready = 1'b1;
      SYNC: begin
        frame_active = 1'b1;
        sequence_out = sync_bits[0];
      end
      DATA: begin
        frame_active = 1'b1;
        sequence_out = data_msb;
      end
      GAP:  frame_active = 1'b1;
      default: load_ready = 1'b0;
    endcase
  end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial frame transmitter, the companion to the team's serial sequence detector. It accepts a parallel data word over a valid/ready handshake. It then drives one serial bit per clock on `sequence_out`: a fixed sync preamble (default 1011), then the data word MSB-first, then a guard gap of zeros. It sits on the transmit side of the serial link and feeds detector-side logic on the far end.

## Interface
- `DATA_W`, default 8: data word width in bits; legal range 1..32.
- `SYNC_W`, default 4: preamble length in bits; legal range 1..8.
- `SYNC_PATTERN`, default 4'b1011: preamble bits, sent MSB-first; width SYNC_W.
- `GAP_W`, default 2: number of guard zeros after the data; legal range 0..15.
- `clock`  input  1  the only clock; all logic runs on its rising edge.
- `reset`  input  1  synchronous, active-low (0 = reset); sampled on the rising edge of `clock`.
- `load_valid`  input  1  `load_data` is valid.
- `load_data`  input  DATA_W  word to transmit.
- `abort`  input  1  terminates the current frame.
- `load_ready`  output  1  block can accept a word.
- `sequence_out`  output  1  serial bit stream, registered.
- `frame_active`  output  1  high while any preamble, data or gap bit is on `sequence_out`.
- `frame_done`  output  1  one-cycle pulse marking a completed frame (not an aborted one).

## Operation
- States: IDLE, SYNC, DATA, GAP.
- IDLE
  - Outputs: `load_ready`=1, `sequence_out`=0, `frame_active`=0.
  - Handshake: a word is accepted on an edge where `load_valid`=1 and `load_ready`=1. The word is captured into the shift register, the bit counter is loaded with SYNC_W-1, and the state goes to SYNC.
- SYNC
  - `sequence_out` = SYNC_PATTERN[counter]; the counter decrements each cycle.
  - When counter = 0, go to DATA with counter = DATA_W-1.
- DATA
  - `sequence_out` = shift register MSB; the register shifts left by one each cycle, filling with 0.
  - When counter = 0: if GAP_W > 0, go to GAP with counter = GAP_W-1; if GAP_W = 0, go to IDLE.
- GAP
  - `sequence_out` = 0.
  - When counter = 0, go to IDLE.
- `frame_done`
  - Asserted for exactly one cycle: the first IDLE cycle after a normal frame end.
  - Never asserted after an abort or a reset.
- `abort`=1 in SYNC, DATA or GAP
  - Next cycle: IDLE, with `sequence_out`=0 and `frame_active`=0.
  - The remaining bits are discarded and `frame_done` stays 0.
- `abort`=1 in IDLE together with `load_valid`=1: abort wins and the word is not accepted.
- Counter width is the bit width needed to hold max(DATA_W, SYNC_W, GAP_W). Counters never wrap; every state exit happens at counter = 0.
- `load_data` is ignored whenever `load_ready`=0. An upstream source must hold its word and keep `load_valid` high until it is accepted.

## Timing
- Reset
  - With `reset`=0 on an edge, the next cycle has: state IDLE, `sequence_out`=0, `frame_active`=0, `frame_done`=0, `load_ready`=1.
  - The shift register and counter are cleared to 0.
  - Reset mid-frame truncates the frame immediately, with no `frame_done`.
- Latency: a word accepted at edge k puts the first preamble bit on `sequence_out` in cycle k+1.
- Frame length: SYNC_W+DATA_W+GAP_W cycles with `frame_active`=1, followed by one IDLE cycle.
- In that IDLE cycle `frame_done`=1 and `load_ready`=1 together. A word held valid is accepted at the end of that cycle.
- Maximum throughput: one frame per SYNC_W+DATA_W+GAP_W+1 cycles.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

## Structure
- Shared package `sequence_pkg` holds:
  - the state encoding (IDLE, SYNC, DATA, GAP as 2-bit localparams);
  - the default sync pattern constant 4'b1011, shared with the detector side;
  - the default widths.
- One sub-module, `serial_shifter`: a parallel-load, MSB-first left-shift register of width DATA_W. Its controls are load and shift enable; its output is the MSB.
- The top level holds the FSM, the bit counter and the output registers.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, then release -> `load_ready`=1, `sequence_out`=0, `frame_active`=0, `frame_done`=0.
- Basic frame: defaults, `load_data`=8'hA5 -> `sequence_out` = 1,0,1,1, 1,0,1,0,0,1,0,1, 0,0 over cycles 1..14, with `frame_active`=1 throughout; in cycle 15, `frame_done`=1.
- Back-to-back: `load_valid` held high with 8'h3C then 8'hFF -> the second preamble starts in cycle 16; there is exactly one IDLE cycle between frames, and `frame_done` pulses once per frame.
- GAP_W=0, DATA_W=4, `load_data`=4'h9 -> 1,0,1,1,1,0,0,1 over 8 cycles, then IDLE with `frame_done`=1.
- Abort: `abort`=1 in data bit 3 of a frame carrying 8'hFF -> the next cycle has `sequence_out`=0 and `frame_active`=0, `frame_done` is never asserted, and `load_ready`=1.
- Reset mid-frame and abort with `load_valid` in IDLE:
  - `reset`=0 in GAP -> next cycle IDLE, no `frame_done`;
  - `abort`=1 with `load_valid`=1 in IDLE -> no frame starts.
